sw_host_ctrl: RTL and testbench

Synthesizable host controller and scoreboard for the SmithWaterman core. It serves the core's target/query SRAM reads from two internal banks with a configurable read latency, issues the start pulse, and tracks the `valid`/`change_q` result stream per (query, target). Each score is checked against an expected-score table and each per-query best match against an internally computed maximum. A watchdog bounds the run. The block sits between the SmithWaterman core and an FPGA/emulation harness, replacing the behavioural memory-and-logging test fixture.

---
 rtl/sw_host_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sw_host_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_host_ctrl.sv
// rtl/sw_host_ctrl.sv - host controller and result scoreboard for the SmithWaterman core
// Serves T/Q bank reads, sequences the start pulse and checks the score stream.
module sw_host_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int WORD_W    = 32,
   parameter int CALC_W    = 12,
   parameter int TIDX_W    = 6,
   parameter int QIDX_W    = 6,
   parameter int EXP_AW    = 10,
   parameter int RD_LAT    = 1,
   parameter int START_DLY = 5,
   parameter int TIMEOUT   = 50000,
   localparam int WA_W     = (ADDR_W > EXP_AW) ? ADDR_W : EXP_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go_i,
   input  logic              wr_en_i,
   input  logic [1:0]        wr_sel_i,
   input  logic [WA_W-1:0]   wr_addr_i,
   input  logic [WORD_W-1:0] wr_data_i,
   input  logic              sel_T_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [WORD_W-1:0] data_o,
   output logic              start_o,
   input  logic              busy_i,
   input  logic              valid_i,
   input  logic [CALC_W-1:0] result_i,
   input  logic              change_q_i,
   input  logic [CALC_W-1:0] max_result_i,
   input  logic [TIDX_W-1:0] match_idx_i,
   output logic              done_o,
   output logic              timeout_o,
   output logic              pass_o,
   output logic [15:0]       err_cnt_o,
   output logic [EXP_AW-1:0] first_err_o,
   output logic [EXP_AW-1:0] res_cnt_o,
   output logic [TIDX_W-1:0] t_idx_o,
   output logic [QIDX_W-1:0] q_idx_o
);

   localparam int DLY_W = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_DELAY, S_START, S_RUN, S_DONE, S_TOUT} state_t;

   state_t state, state_nxt;

   logic [DLY_W-1:0]  dly_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic              enter_delay;
   logic              load_ok;

   logic [WORD_W-1:0] t_mem   [1 << ADDR_W];
   logic [WORD_W-1:0] q_mem   [1 << ADDR_W];
   logic [CALC_W-1:0] exp_mem [1 << EXP_AW];
   logic [WORD_W-1:0] rd1;

   logic [CALC_W-1:0] max_val, max_nxt, exp_rd;
   logic [TIDX_W-1:0] max_idx, idx_nxt;
   logic              score_err, max_err;
   logic [1:0]        err_inc;
   logic [16:0]       err_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         dly_cnt <= '0;
         wd_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         dly_cnt <= (state == S_DELAY) ? dly_cnt + 1'b1 : '0;
         wd_cnt  <= (state == S_START || state == S_RUN) ? wd_cnt + 1'b1 : '0;
      end
   end

   // wd_cnt is 0 in START and 1 in the first RUN cycle, so busy_i counts from 2 on
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_TOUT: if (go_i) state_nxt = S_DELAY;
         S_DELAY: if (dly_cnt == DLY_W'(START_DLY)) state_nxt = S_START;
         S_START: state_nxt = S_RUN;
         S_RUN: begin
            if (wd_cnt >= WD_W'(2) && !busy_i)
               state_nxt = S_DONE;
            else if (wd_cnt >= WD_W'(TIMEOUT - 1))
               state_nxt = S_TOUT;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign enter_delay = (state_nxt == S_DELAY) && (state != S_DELAY);
   assign load_ok     = (state == S_IDLE) || (state == S_DONE) || (state == S_TOUT);
   assign start_o     = (state == S_START);
   assign done_o      = (state == S_DONE);
   assign timeout_o   = (state == S_TOUT);
   assign pass_o      = done_o && (err_cnt_o == '0);

   always_ff @(posedge clk) begin
      if (wr_en_i && load_ok) begin
         case (wr_sel_i)
            2'd0: t_mem[wr_addr_i[ADDR_W-1:0]]   <= wr_data_i;
            2'd1: q_mem[wr_addr_i[ADDR_W-1:0]]   <= wr_data_i;
            2'd2: exp_mem[wr_addr_i[EXP_AW-1:0]] <= wr_data_i[CALC_W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd1 <= '0;
      else        rd1 <= sel_T_i ? t_mem[addr_i] : q_mem[addr_i];
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [WORD_W-1:0] rd2;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd2 <= '0;
            else        rd2 <= rd1;
         end
         assign data_o = rd2;
      end else begin : g_lat1
         assign data_o = rd1;
      end
   endgenerate

   // The query-end comparison sees the running max including the current result
   always_comb begin
      exp_rd    = exp_mem[res_cnt_o];
      score_err = (result_i != exp_rd);
      max_nxt   = max_val;
      idx_nxt   = max_idx;
      if (result_i > max_val) begin
         max_nxt = result_i;
         idx_nxt = t_idx_o;
      end
      max_err = change_q_i && ((max_result_i != max_nxt) || (match_idx_i != idx_nxt));
      err_inc = {1'b0, score_err} + {1'b0, max_err};
      err_sum = {1'b0, err_cnt_o} + {15'd0, err_inc};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_o   <= '0;
         first_err_o <= '0;
         res_cnt_o   <= '0;
         t_idx_o     <= '0;
         q_idx_o     <= '0;
         max_val     <= '0;
         max_idx     <= '0;
      end else if (enter_delay) begin
         err_cnt_o   <= '0;
         first_err_o <= '0;
         res_cnt_o   <= '0;
         t_idx_o     <= '0;
         q_idx_o     <= '0;
         max_val     <= '0;
         max_idx     <= '0;
      end else if (state == S_RUN && valid_i) begin
         res_cnt_o <= res_cnt_o + 1'b1;
         err_cnt_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
         if (err_cnt_o == '0 && err_inc != 2'd0)
            first_err_o <= res_cnt_o;
         if (change_q_i) begin
            t_idx_o <= '0;
            q_idx_o <= q_idx_o + 1'b1;
            max_val <= '0;
            max_idx <= '0;
         end else begin
            t_idx_o <= t_idx_o + 1'b1;
            max_val <= max_nxt;
            max_idx <= idx_nxt;
         end
      end
   end

endmodule

// File: tb/tb_sw_host_ctrl.sv
// tb/tb_sw_host_ctrl.sv - self-checking bench for sw_host_ctrl
// Runs scenario tasks in sequence against a spec-level scoreboard model.
module tb_sw_host_ctrl;

   localparam int START_DLY = 5;
   localparam int TIMEOUT   = 100;

   logic        clk = 1'b0;
   logic        rst_n, go_i, wr_en_i, sel_T_i, busy_i, valid_i, change_q_i;
   logic [1:0]  wr_sel_i;
   logic [9:0]  wr_addr_i;
   logic [31:0] wr_data_i;
   logic [7:0]  addr_i;
   logic [11:0] result_i, max_result_i;
   logic [5:0]  match_idx_i;

   logic [31:0] data_o, data_o_2;
   logic        start_o, done_o, timeout_o, pass_o;
   logic        start_o_2, done_o_2, timeout_o_2, pass_o_2;
   logic [15:0] err_cnt_o, err_cnt_o_2;
   logic [9:0]  first_err_o, res_cnt_o, first_err_o_2, res_cnt_o_2;
   logic [5:0]  t_idx_o, q_idx_o, t_idx_o_2, q_idx_o_2;

   int n_chk = 0;
   int n_err = 0;

   int m_res, m_err, m_first, m_t, m_q;
   int qres[$];
   int exp_m [1024];
   logic [31:0] tm [256];
   logic [31:0] qm [256];

   always #5 clk = ~clk;

   sw_host_ctrl #(.RD_LAT(1), .START_DLY(START_DLY), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .go_i(go_i), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .sel_T_i(sel_T_i), .addr_i(addr_i),
      .data_o(data_o), .start_o(start_o), .busy_i(busy_i), .valid_i(valid_i),
      .result_i(result_i), .change_q_i(change_q_i), .max_result_i(max_result_i),
      .match_idx_i(match_idx_i), .done_o(done_o), .timeout_o(timeout_o), .pass_o(pass_o),
      .err_cnt_o(err_cnt_o), .first_err_o(first_err_o), .res_cnt_o(res_cnt_o),
      .t_idx_o(t_idx_o), .q_idx_o(q_idx_o));

   sw_host_ctrl #(.RD_LAT(2), .START_DLY(START_DLY), .TIMEOUT(TIMEOUT)) dut2 (
      .clk(clk), .rst_n(rst_n), .go_i(go_i), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .sel_T_i(sel_T_i), .addr_i(addr_i),
      .data_o(data_o_2), .start_o(start_o_2), .busy_i(busy_i), .valid_i(valid_i),
      .result_i(result_i), .change_q_i(change_q_i), .max_result_i(max_result_i),
      .match_idx_i(match_idx_i), .done_o(done_o_2), .timeout_o(timeout_o_2), .pass_o(pass_o_2),
      .err_cnt_o(err_cnt_o_2), .first_err_o(first_err_o_2), .res_cnt_o(res_cnt_o_2),
      .t_idx_o(t_idx_o_2), .q_idx_o(q_idx_o_2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int sel, input int addr, input logic [31:0] data);
      wr_sel_i  = 2'(sel);
      wr_addr_i = 10'(addr);
      wr_data_i = data;
      wr_en_i   = 1'b1;
      tick();
      wr_en_i   = 1'b0;
   endtask

   task automatic model_reset();
      m_res = 0; m_err = 0; m_first = 0; m_t = 0; m_q = 0;
      qres.delete();
   endtask

   task automatic add_err();
      if (m_err == 0) m_first = m_res;
      if (m_err < 65535) m_err++;
   endtask

   // Best score of the current query (max starts at 0, earliest target wins ties)
   task automatic ref_best(input int r, output int b, output int bi);
      b = 0; bi = 0;
      foreach (qres[i]) if (qres[i] > b) begin b = qres[i]; bi = i; end
      if (r > b) begin b = r; bi = qres.size(); end
   endtask

   task automatic model_valid(input int r, input int chg, input int mx, input int mi);
      int b, bi;
      if (r != exp_m[m_res]) add_err();
      ref_best(r, b, bi);
      qres.push_back(r);
      if (chg != 0) begin
         if (mx != b || mi != bi % 64) add_err();
         qres.delete();
         m_t = 0;
         m_q = (m_q + 1) % 64;
      end else begin
         m_t = (m_t + 1) % 64;
      end
      m_res = (m_res + 1) % 1024;
   endtask

   task automatic send(input int r, input int chg, input int mx, input int mi, input bit upd);
      result_i     = 12'(r);
      change_q_i   = (chg != 0);
      max_result_i = 12'(mx);
      match_idx_i  = 6'(mi);
      valid_i      = 1'b1;
      tick();
      valid_i      = 1'b0;
      change_q_i   = 1'b0;
      if (upd) model_valid(r, chg, mx, mi);
   endtask

   // Leaves the bench in the first RUN cycle
   task automatic launch();
      busy_i = 1'b1;
      go_i   = 1'b1;
      tick();
      go_i   = 1'b0;
      model_reset();
      for (int k = 0; k < 20 && !start_o; k++) tick();
      n_chk++;
      if (start_o !== 1'b1) begin
         n_err++;
         $display("FAIL launch_start: start_o=%b required 1 within 20 cycles", start_o);
      end
      tick();
   endtask

   task automatic test_reset();
      n_chk++;
      if ({start_o, done_o, timeout_o, pass_o} !== 4'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b required 0000", {start_o, done_o, timeout_o, pass_o});
      end
      n_chk++;
      if (err_cnt_o !== 16'd0 || first_err_o !== 10'd0 || res_cnt_o !== 10'd0) begin
         n_err++;
         $display("FAIL reset_counts: err=%0d first=%0d res=%0d required 0", err_cnt_o, first_err_o, res_cnt_o);
      end
      n_chk++;
      if (t_idx_o !== 6'd0 || q_idx_o !== 6'd0) begin
         n_err++;
         $display("FAIL reset_idx: t=%0d q=%0d required 0", t_idx_o, q_idx_o);
      end
      n_chk++;
      if (data_o !== 32'd0 || data_o_2 !== 32'd0) begin
         n_err++;
         $display("FAIL reset_data: lat1=%h lat2=%h required 0", data_o, data_o_2);
      end
   endtask

   task automatic test_read();
      int hist [32];
      int a;
      load(0, 3, 32'hA5A5A5A5); tm[3] = 32'hA5A5A5A5;
      load(1, 3, 32'h5A5A5A5A); qm[3] = 32'h5A5A5A5A;
      for (int i = 10; i < 18; i++) begin
         tm[i] = $urandom; load(0, i, tm[i]);
         qm[i] = $urandom; load(1, i, qm[i]);
      end
      sel_T_i = 1'b1; addr_i = 8'd3;
      tick();
      n_chk++;
      if (data_o !== 32'hA5A5A5A5) begin
         n_err++;
         $display("FAIL read_t_lat1: got %h required a5a5a5a5", data_o);
      end
      sel_T_i = 1'b0;
      tick();
      n_chk++;
      if (data_o !== 32'h5A5A5A5A || data_o_2 !== 32'hA5A5A5A5) begin
         n_err++;
         $display("FAIL read_q_lat1_t_lat2: got %h/%h required 5a5a5a5a/a5a5a5a5", data_o, data_o_2);
      end
      tick();
      n_chk++;
      if (data_o_2 !== 32'h5A5A5A5A) begin
         n_err++;
         $display("FAIL read_q_lat2: got %h required 5a5a5a5a", data_o_2);
      end
      for (int i = 0; i < 24; i++) begin
         a = ($urandom_range(0, 8) == 0) ? 3 : $urandom_range(10, 17);
         sel_T_i = $urandom_range(0, 1) == 1;
         addr_i  = 8'(a);
         hist[i] = sel_T_i ? tm[a] : qm[a];
         tick();
         n_chk++;
         if (data_o !== 32'(hist[i])) begin
            n_err++;
            $display("FAIL read_pipe_lat1[%0d]: got %h required %h", i, data_o, 32'(hist[i]));
         end
         if (i > 0) begin
            n_chk++;
            if (data_o_2 !== 32'(hist[i-1])) begin
               n_err++;
               $display("FAIL read_pipe_lat2[%0d]: got %h required %h", i, data_o_2, 32'(hist[i-1]));
            end
         end
      end
   endtask

   task automatic test_start();
      int seen = 0;
      busy_i = 1'b1;
      go_i   = 1'b1;
      tick();
      go_i   = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_chk++;
         if (start_o !== (k == START_DLY + 1)) begin
            n_err++;
            $display("FAIL start_timing[k=%0d]: start_o=%b required %b", k, start_o, k == START_DLY + 1);
         end
      end
      go_i = 1'b1;
      tick();
      go_i = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (start_o) seen++;
         tick();
      end
      n_chk++;
      if (seen != 0 || done_o !== 1'b0) begin
         n_err++;
         $display("FAIL start_go_in_run: extra starts=%0d done=%b required 0/0", seen, done_o);
      end
      busy_i = 1'b0;
      tick();
      n_chk++;
      if (done_o !== 1'b1 || pass_o !== 1'b1) begin
         n_err++;
         $display("FAIL start_done: done=%b pass=%b required 1/1", done_o, pass_o);
      end
   endtask

   task automatic test_random();
      int r, chg, b, bi, mx, mi;
      for (int i = 0; i < 40; i++) begin
         exp_m[i] = $urandom_range(0, 15);
         load(2, i, 32'(exp_m[i]));
      end
      launch();
      for (int i = 0; i < 32; i++) begin
         r   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : exp_m[m_res];
         chg = ($urandom_range(0, 4) == 0 || i == 31) ? 1 : 0;
         ref_best(r, b, bi);
         mx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : b;
         mi  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : bi;
         send(r, chg, mx, mi, 1'b1);
         n_chk++;
         if (err_cnt_o !== 16'(m_err) || res_cnt_o !== 10'(m_res)) begin
            n_err++;
            $display("FAIL rand_counts[%0d]: err=%0d res=%0d required %0d/%0d", i, err_cnt_o, res_cnt_o, m_err, m_res);
         end
         n_chk++;
         if (t_idx_o !== 6'(m_t) || q_idx_o !== 6'(m_q)) begin
            n_err++;
            $display("FAIL rand_idx[%0d]: t=%0d q=%0d required %0d/%0d", i, t_idx_o, q_idx_o, m_t, m_q);
         end
         if ($urandom_range(0, 2) == 0) tick();
      end
      n_chk++;
      if (first_err_o !== 10'(m_first)) begin
         n_err++;
         $display("FAIL rand_first_err: got %0d required %0d", first_err_o, m_first);
      end
      busy_i = 1'b0;
      tick();
      n_chk++;
      if (done_o !== 1'b1 || pass_o !== (m_err == 0)) begin
         n_err++;
         $display("FAIL rand_done: done=%b pass=%b required 1/%b", done_o, pass_o, m_err == 0);
      end
      send(7, 1, 0, 0, 1'b0);
      n_chk++;
      if (res_cnt_o !== 10'(m_res) || err_cnt_o !== 16'(m_err)) begin
         n_err++;
         $display("FAIL valid_outside_run: res=%0d err=%0d required %0d/%0d", res_cnt_o, err_cnt_o, m_res, m_err);
      end
   endtask

   task automatic test_pass();
      exp_m[0] = 10; exp_m[1] = 25; exp_m[2] = 25;
      load(2, 0, 32'd10); load(2, 1, 32'd25); load(2, 2, 32'd25);
      launch();
      send(10, 0, 0, 0, 1'b1);
      send(25, 0, 0, 0, 1'b1);
      send(25, 1, 25, 1, 1'b1);
      n_chk++;
      if (err_cnt_o !== 16'd0 || q_idx_o !== 6'd1 || t_idx_o !== 6'd0) begin
         n_err++;
         $display("FAIL pass_counts: err=%0d q=%0d t=%0d required 0/1/0", err_cnt_o, q_idx_o, t_idx_o);
      end
      busy_i = 1'b0;
      tick();
      n_chk++;
      if (done_o !== 1'b1 || pass_o !== 1'b1) begin
         n_err++;
         $display("FAIL pass_done: done=%b pass=%b required 1/1", done_o, pass_o);
      end
   endtask

   task automatic test_errors();
      launch();
      send(11, 0, 0, 0, 1'b1);
      send(25, 0, 0, 0, 1'b1);
      send(25, 1, 25, 2, 1'b1);
      n_chk++;
      if (err_cnt_o !== 16'd2 || first_err_o !== 10'd0 || m_err != 2) begin
         n_err++;
         $display("FAIL errors_counts: err=%0d first=%0d required 2/0", err_cnt_o, first_err_o);
      end
      busy_i = 1'b0;
      tick();
      n_chk++;
      if (done_o !== 1'b1 || pass_o !== 1'b0) begin
         n_err++;
         $display("FAIL errors_done: done=%b pass=%b required 1/0", done_o, pass_o);
      end
   endtask

   task automatic test_timeout();
      launch();
      for (int k = 2; k <= TIMEOUT; k++) begin
         tick();
         if (k == TIMEOUT - 1) begin
            n_chk++;
            if (timeout_o !== 1'b0) begin
               n_err++;
               $display("FAIL timeout_early: timeout=%b required 0 at cycle %0d", timeout_o, k);
            end
         end
      end
      n_chk++;
      if (timeout_o !== 1'b1 || done_o !== 1'b0 || pass_o !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_fire: timeout=%b done=%b pass=%b required 1/0/0", timeout_o, done_o, pass_o);
      end
      launch();
      for (int k = 2; k < TIMEOUT; k++) tick();
      busy_i = 1'b0;
      tick();
      n_chk++;
      if (done_o !== 1'b1 || timeout_o !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_done_wins: done=%b timeout=%b required 1/0", done_o, timeout_o);
      end
   endtask

   task automatic test_reset_midrun();
      launch();
      send(10, 0, 0, 0, 1'b1);
      load(0, 3, 32'hDEADBEEF);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({start_o, done_o, timeout_o, pass_o, err_cnt_o, first_err_o, res_cnt_o, t_idx_o, q_idx_o, data_o} !== '0) begin
         n_err++;
         $display("FAIL rst_mid_outputs: res=%0d t=%0d data=%h required all 0", res_cnt_o, t_idx_o, data_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      launch();
      send(10, 0, 0, 0, 1'b1);
      send(25, 0, 0, 0, 1'b1);
      send(25, 1, 25, 1, 1'b1);
      n_chk++;
      if (err_cnt_o !== 16'd0 || q_idx_o !== 6'd1 || t_idx_o !== 6'd0 || res_cnt_o !== 10'd3) begin
         n_err++;
         $display("FAIL rst_rerun_counts: err=%0d q=%0d t=%0d res=%0d required 0/1/0/3", err_cnt_o, q_idx_o, t_idx_o, res_cnt_o);
      end
      busy_i = 1'b0;
      tick();
      n_chk++;
      if (done_o !== 1'b1 || pass_o !== 1'b1) begin
         n_err++;
         $display("FAIL rst_rerun_done: done=%b pass=%b required 1/1", done_o, pass_o);
      end
      sel_T_i = 1'b1; addr_i = 8'd3;
      tick();
      n_chk++;
      if (data_o !== 32'hA5A5A5A5) begin
         n_err++;
         $display("FAIL rst_mem_kept: got %h required a5a5a5a5", data_o);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; go_i = 1'b0; wr_en_i = 1'b0; wr_sel_i = 2'd3; wr_addr_i = '0; wr_data_i = '0;
      sel_T_i = 1'b0; addr_i = '0; busy_i = 1'b1; valid_i = 1'b0; result_i = '0;
      change_q_i = 1'b0; max_result_i = '0; match_idx_i = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      test_read();
      test_start();
      test_random();
      test_pass();
      test_errors();
      test_timeout();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
